// File: rtl/life_sequencer_if.sv
// Board-download bus between the HPS host and the Life sequencer.
interface life_sequencer_if;
  logic       dl_active;
  logic       dl_wr;
  logic [7:0] dl_data;
  logic       dl_wait;

  modport master (output dl_active, output dl_wr, output dl_data, input dl_wait);
  modport slave  (input dl_active, input dl_wr, input dl_data, output dl_wait);
endinterface

// File: rtl/life_sequencer.sv
// Frame-level sequencer for the Game of Life datapath: decodes run-length
// downloads into shift pulses, aligns to frame start and picks evolve/copy
// once per frame.
module life_sequencer #(
  parameter int CELLS = 2073600,
  parameter int DIV_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  life_sequencer_if.slave   dl,
  input  logic              frame_start,
  input  logic              run,
  input  logic              step,
  input  logic [DIV_W-1:0]  frame_div,
  output logic              shift_en,
  output logic              load_sel,
  output logic              load_bit,
  output logic              evolve,
  output logic [31:0]       gen_count,
  output logic              load_overflow
);

  localparam int CNT_W = $clog2(CELLS + 1);
  localparam logic [CNT_W-1:0] CELLS_C = CNT_W'(CELLS);

  typedef enum logic [1:0] {SYNC, LOAD, SCAN} state_t;

  state_t           state_q, state_d;
  logic [7:0]       remain_q, remain_d;
  logic [CNT_W-1:0] cell_cnt_q, cell_cnt_d;
  logic             ovf_q, ovf_d;
  logic             step_pend_q, step_pend_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             evolve_q, evolve_d;
  logic [31:0]      gen_q, gen_d;
  logic             load_bit_q, load_bit_d;
  logic             dl_active_q;
  logic             dl_rise;
  logic             frame_upd;
  logic             load_room;

  assign dl_rise   = dl.dl_active & ~dl_active_q;
  assign load_room = (cell_cnt_q < CELLS_C);

  // Datapath controls depend only on registered state so they are glitch-free
  // across the frame and a dl_active rise only takes effect on the next cycle.
  assign shift_en = (state_q == SCAN) ||
                    ((state_q == LOAD) && (remain_q != 8'd0) && load_room);
  assign load_sel = (state_q == LOAD);
  assign dl.dl_wait = dl.dl_active & (remain_q != 8'd0);

  assign load_bit      = load_bit_q;
  assign evolve        = evolve_q;
  assign gen_count     = gen_q;
  assign load_overflow = ovf_q;

  // State register and all sequencer counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= SYNC;
      remain_q    <= '0;
      cell_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      step_pend_q <= 1'b0;
      div_q       <= '0;
      evolve_q    <= 1'b0;
      gen_q       <= '0;
      load_bit_q  <= 1'b0;
      dl_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      cell_cnt_q  <= cell_cnt_d;
      ovf_q       <= ovf_d;
      step_pend_q <= step_pend_d;
      div_q       <= div_d;
      evolve_q    <= evolve_d;
      gen_q       <= gen_d;
      load_bit_q  <= load_bit_d;
      dl_active_q <= dl.dl_active;
    end
  end

  // Next state: download decode, frame alignment and the per-frame evolve decision.
  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    cell_cnt_d  = cell_cnt_q;
    ovf_d       = ovf_q;
    step_pend_d = step_pend_q;
    div_d       = div_q;
    evolve_d    = evolve_q;
    gen_d       = gen_q;
    load_bit_d  = load_bit_q;
    frame_upd   = 1'b0;

    if (step && !run) step_pend_d = 1'b1;

    if (dl_rise) begin
      // A new download abandons whatever was going on, even a load in flight.
      state_d     = LOAD;
      remain_d    = '0;
      cell_cnt_d  = '0;
      ovf_d       = 1'b0;
      step_pend_d = 1'b0;
      div_d       = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (remain_q != 8'd0) begin
            remain_d = remain_q - 8'd1;
            if (load_room) cell_cnt_d = cell_cnt_q + 1'b1;
            else           ovf_d      = 1'b1;
          end else if (!dl.dl_active) begin
            state_d  = SYNC;
            gen_d    = '0;
            evolve_d = 1'b0;
          end else if (dl.dl_wr) begin
            load_bit_d = dl.dl_data[7];
            remain_d   = {1'b0, dl.dl_data[6:0]} + 8'd1;
          end
        end
        SYNC: begin
          if (frame_start) begin
            state_d   = SCAN;
            frame_upd = 1'b1;
          end
        end
        SCAN: begin
          if (frame_start) frame_upd = 1'b1;
        end
        default: state_d = SYNC;
      endcase
    end

    // ">=" lets a shrunk frame_div pull an overshot divider back to zero
    // without producing an evolve frame.
    if (frame_upd) begin
      if (run) begin
        evolve_d = (div_q == frame_div);
        div_d    = (div_q >= frame_div) ? '0 : div_q + 1'b1;
      end else begin
        evolve_d    = step_pend_q | step;
        step_pend_d = 1'b0;
        div_d       = '0;
      end
      if (evolve_d) gen_d = gen_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_life_sequencer.sv
// Directed bench for life_sequencer with a small board (CELLS=20).
module tb_life_sequencer;
  logic        clock;
  logic        reset;
  logic        frame_start, run, step;
  logic [7:0]  frame_div;
  logic        shift_en, load_sel, load_bit, evolve, load_overflow;
  logic [31:0] gen_count;
  int          n_chk = 0;
  int          n_pass = 0;

  life_sequencer_if dl();

  life_sequencer #(.CELLS(20), .DIV_W(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .dl            (dl),
    .frame_start   (frame_start),
    .run           (run),
    .step          (step),
    .frame_div     (frame_div),
    .shift_en      (shift_en),
    .load_sel      (load_sel),
    .load_bit      (load_bit),
    .evolve        (evolve),
    .gen_count     (gen_count),
    .load_overflow (load_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Send one byte while remain=0, then count pulses while dl_wait stays high.
  task automatic burst(input logic [7:0] b, output int pulses, output int bad);
    dl.dl_wr = 1'b1; dl.dl_data = b;
    tick();
    dl.dl_wr = 1'b0;
    pulses = 0; bad = 0;
    for (int i = 0; i < 300 && dl.dl_wait; i++) begin
      if (shift_en) begin
        pulses++;
        if (load_bit !== b[7]) bad++;
      end
      tick();
    end
    if (dl.dl_wait !== 1'b0) bad++;
  endtask

  initial begin
    int p, bad, cnt;
    logic [8:0] ev_s, ev_e;
    logic [5:0] ev6;

    reset = 1'b1; frame_start = 0; run = 0; step = 0; frame_div = 0;
    dl.dl_active = 0; dl.dl_wr = 0; dl.dl_data = 0;
    repeat (3) tick();
    chk("rst_shift", shift_en, 0);
    chk("rst_load_sel", load_sel, 0);
    chk("rst_evolve", evolve, 0);
    chk("rst_gen", gen_count, 0);
    chk("rst_ovf", load_overflow, 0);
    reset = 1'b0;
    tick();

    // Reset in the middle of a 50-cell run.
    dl.dl_active = 1; tick();
    dl.dl_wr = 1; dl.dl_data = 8'hB1; tick(); dl.dl_wr = 0;
    chk("midload_shift_pre", shift_en, 1);
    reset = 1'b1; #1;
    chk("arst_shift", shift_en, 0);
    chk("arst_load_sel", load_sel, 0);
    chk("arst_load_bit", load_bit, 0);
    chk("arst_dl_wait", dl.dl_wait, 0);
    dl.dl_active = 0;
    tick();
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (shift_en) cnt++; end
    chk("post_rst_no_shift", cnt, 0);
    frame_start = 1; tick(); frame_start = 0;
    chk("scan_after_fs", shift_en, 1);
    chk("scan_no_evolve", evolve, 0);

    // Download 0x85, 0x02.
    dl.dl_active = 1; tick();
    chk("load_sel_rise", load_sel, 1);
    chk("shift_drop_rise", shift_en, 0);
    burst(8'h85, p, bad);
    chk("b85_pulses", p, 6);
    chk("b85_bad", bad, 0);
    burst(8'h02, p, bad);
    chk("b02_pulses", p, 3);
    chk("b02_bad", bad, 0);
    dl.dl_active = 0; tick();
    chk("exit_load_sel", load_sel, 0);
    chk("exit_gen", gen_count, 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (shift_en) cnt++; end
    chk("sync_no_shift", cnt, 0);

    // Overflow: 30 cells into a 20-cell board.
    dl.dl_active = 1; tick();
    burst(8'h8E, p, bad);
    chk("ovf_b1_pulses", p, 15);
    chk("ovf_b1_ovf", load_overflow, 0);
    burst(8'h0E, p, bad);
    chk("ovf_b2_pulses", p, 5);
    chk("ovf_b2_bad", bad, 0);
    chk("ovf_set", load_overflow, 1);
    dl.dl_active = 0; tick();
    chk("ovf_sticky", load_overflow, 1);

    // Free run, frame_div=2.
    run = 1; frame_div = 2;
    for (int f = 0; f < 9; f++) begin
      frame_start = 1; tick(); frame_start = 0;
      ev_s[f] = evolve;
      repeat (3) tick();
      ev_e[f] = evolve;
    end
    chk("run_ev_start", ev_s, 9'b100100100);
    chk("run_ev_end", ev_e, 9'b100100100);
    chk("run_gen", gen_count, 3);
    chk("run_shift", shift_en, 1);

    // Divider overshoot after frame_div shrinks.
    for (int f = 0; f < 6; f++) begin
      frame_div = (f < 3) ? 8'd3 : 8'd1;
      frame_start = 1; tick(); frame_start = 0;
      ev6[f] = evolve;
      repeat (2) tick();
    end
    chk("div_shrink_ev", ev6, 6'b100000);
    chk("div_shrink_gen", gen_count, 4);

    // Single step.
    run = 0;
    frame_start = 1; tick(); frame_start = 0;
    chk("step_idle_ev", evolve, 0);
    repeat (2) tick();
    frame_start = 1; step = 1; tick(); frame_start = 0; step = 0;
    chk("step_coinc_ev", evolve, 1);
    repeat (2) tick();
    frame_start = 1; tick(); frame_start = 0;
    chk("step_next_ev", evolve, 0);
    repeat (2) tick();
    step = 1; tick(); step = 0;
    chk("step_pend_holds", evolve, 0);
    tick();
    frame_start = 1; tick(); frame_start = 0;
    chk("step_mid_ev", evolve, 1);
    chk("step_gen", gen_count, 6);

    // Download start in the middle of SCAN, dl_active falls with remain=3.
    tick();
    chk("ovf_before_dl", load_overflow, 1);
    dl.dl_active = 1; tick();
    chk("midscan_shift_drop", shift_en, 0);
    chk("midscan_ovf_clr", load_overflow, 0);
    dl.dl_wr = 1; dl.dl_data = 8'h05; tick(); dl.dl_wr = 0;
    repeat (3) tick();
    chk("midscan_wait", dl.dl_wait, 1);
    dl.dl_active = 0;
    p = 0;
    for (int i = 0; i < 20 && shift_en; i++) begin p++; tick(); end
    chk("tail_pulses", p, 3);
    tick();
    chk("tail_sync_sel", load_sel, 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (shift_en) cnt++; end
    chk("tail_no_shift", cnt, 0);
    chk("tail_gen", gen_count, 0);
    frame_start = 1; tick(); frame_start = 0;
    chk("tail_scan", shift_en, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
